act_skew_feeder: RTL and testbench

- Upstream stage of the GEMM systolic array. Accepts one unskewed activation vector per handshake, one element per array column.
- Emits a diagonally skewed stream: column c is delayed by c advance steps, then an (ARRAY_SIZE-1)-step zero drain.
- The output drives the array's activation_in/activation_valid inputs directly, with zero fill on the leading and trailing edges.

---
 rtl/act_skew_feeder.sv | 140 ++++++++++++++
 tb/tb_act_skew_feeder.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/act_skew_feeder.sv
// Activation skew feeder: turns one unskewed vector per handshake into the diagonal
// wavefront a systolic array expects, then flushes the skew with zero-filled steps.
module act_skew_feeder #(
  parameter int DATA_WIDTH  = 8,
  parameter int ARRAY_SIZE  = 16,
  parameter int MAX_VECTORS = 256
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             start,
  input  logic [$clog2(MAX_VECTORS+1)-1:0] num_vectors,
  input  logic                             abort,
  input  logic [DATA_WIDTH*ARRAY_SIZE-1:0] in_data,
  input  logic                             in_valid,
  output logic                             in_ready,
  output logic [DATA_WIDTH*ARRAY_SIZE-1:0] act_out,
  output logic                             act_valid,
  output logic                             act_last,
  output logic                             busy,
  output logic                             done
);

  localparam int CNT_W = $clog2(MAX_VECTORS + 1);
  localparam int DRN_W = (ARRAY_SIZE > 1) ? $clog2(ARRAY_SIZE) : 1;
  localparam logic [DRN_W-1:0] DRAIN_LAST = DRN_W'((ARRAY_SIZE > 1) ? ARRAY_SIZE - 2 : 0);
  localparam int VEC_W = DATA_WIDTH * ARRAY_SIZE;

  typedef enum logic [1:0] {
    IDLE,
    FEED,
    DRAIN
  } state_t;

  state_t             state;
  state_t             state_next;
  logic [CNT_W-1:0]   vec_left;
  logic [DRN_W-1:0]   drain_cnt;

  logic               start_ok;
  logic               load;
  logic               accept;
  logic               last_accept;
  logic               drain_end;
  logic               advance;
  logic               final_beat;
  logic               clear_skew;
  logic [VEC_W-1:0]   elem_in;
  logic [VEC_W-1:0]   out_next;

  // busy stays high through the act_last beat so it falls together with done
  assign busy        = (state != IDLE) | act_last;
  assign in_ready    = (state == FEED);
  assign start_ok    = start & ~busy & ~abort;
  assign load        = start_ok & (num_vectors != '0);
  assign accept      = in_valid & in_ready & ~abort;
  assign last_accept = accept & (vec_left == CNT_W'(1));
  assign drain_end   = (state == DRAIN) & (drain_cnt == DRAIN_LAST);
  assign advance     = accept | ((state == DRAIN) & ~abort);
  assign final_beat  = ~abort & (drain_end | (last_accept & (ARRAY_SIZE == 1)));
  assign clear_skew  = abort | load;
  assign elem_in     = (state == DRAIN) ? '0 : in_data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (load) state_next = FEED;
      FEED:    if (last_accept) state_next = (ARRAY_SIZE > 1) ? DRAIN : IDLE;
      DRAIN:   if (drain_end) state_next = IDLE;
      default: state_next = IDLE;
    endcase
    if (abort) state_next = IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vec_left  <= '0;
      drain_cnt <= '0;
    end else begin
      if (abort) begin
        vec_left <= '0;
      end else if (load) begin
        vec_left <= num_vectors;
      end else if (accept) begin
        vec_left <= vec_left - CNT_W'(1);
      end
      if ((state == DRAIN) && !abort && !drain_end) begin
        drain_cnt <= drain_cnt + DRN_W'(1);
      end else begin
        drain_cnt <= '0;
      end
    end
  end

  // Column 0 feeds the output register directly; column c goes through c stages first
  assign out_next[DATA_WIDTH-1:0] = elem_in[DATA_WIDTH-1:0];

  for (genvar c = 1; c < ARRAY_SIZE; c++) begin : g_col
    logic [DATA_WIDTH-1:0] stage_q [c];

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        for (int j = 0; j < c; j++) stage_q[j] <= '0;
      end else if (clear_skew) begin
        for (int j = 0; j < c; j++) stage_q[j] <= '0;
      end else if (advance) begin
        stage_q[0] <= elem_in[c*DATA_WIDTH +: DATA_WIDTH];
        for (int j = 1; j < c; j++) stage_q[j] <= stage_q[j-1];
      end
    end

    assign out_next[c*DATA_WIDTH +: DATA_WIDTH] = stage_q[c-1];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      act_out   <= '0;
      act_valid <= 1'b0;
      act_last  <= 1'b0;
      done      <= 1'b0;
    end else begin
      if (abort) begin
        act_out <= '0;
      end else if (advance) begin
        act_out <= out_next;
      end
      act_valid <= advance;
      act_last  <= final_beat;
      done      <= ~abort & (act_last | (start_ok & (num_vectors == '0)));
    end
  end

endmodule

// File: tb/tb_act_skew_feeder.sv
// Bench for act_skew_feeder: random tiles with stalls, checked beat by beat against
// a diagonal-wavefront model (beat b, column c carries vector b-c or zero).
module tb_act_skew_feeder;

  localparam int DW   = 8;
  localparam int A    = 4;
  localparam int MAXV = 16;
  localparam int CW   = $clog2(MAXV + 1);
  localparam int VW   = DW * A;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic [CW-1:0] num_vectors;
  logic          abort;
  logic [VW-1:0] in_data;
  logic          in_valid;
  logic          in_ready;
  logic [VW-1:0] act_out;
  logic          act_valid;
  logic          act_last;
  logic          busy;
  logic          done;

  int            nCompared = 0;
  int            nMismatched = 0;
  logic [VW-1:0] vecs [MAXV];
  logic [VW-1:0] lastOut;
  bit            haveLast;

  always #5 clk = ~clk;

  act_skew_feeder #(
    .DATA_WIDTH (DW),
    .ARRAY_SIZE (A),
    .MAX_VECTORS(MAXV)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .num_vectors(num_vectors),
    .abort      (abort),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .act_out    (act_out),
    .act_valid  (act_valid),
    .act_last   (act_last),
    .busy       (busy),
    .done       (done)
  );

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nCompared++;
    if (got !== exp) begin
      nMismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Beat b of an n-vector tile: column c shows vector b-c when that vector exists
  function automatic logic [VW-1:0] expBeat(input int n, input int b);
    logic [VW-1:0] r;
    r = '0;
    for (int c = 0; c < A; c++) begin
      int k;
      k = b - c;
      if (k >= 0 && k < n) r[c*DW +: DW] = vecs[k][c*DW +: DW];
    end
    return r;
  endfunction

  task automatic fillRandom(input int n);
    for (int i = 0; i < n; i++) vecs[i] = VW'($urandom);
  endtask

  task automatic idleCycles(input int k);
    start = 0;
    in_valid = 0;
    repeat (k) begin
      @(posedge clk); #1;
      checkOutput("idleValid", act_valid, 0);
    end
  endtask

  // One tile. stallPct<0 means a fixed gap of -stallPct cycles after the first vector.
  // abortAfter>=0 aborts once that many beats have been seen.
  task automatic applyStimulus(input int n, input int stallPct, input int abortAfter, input bit midStart);
    int total, idx, beat, drainLeft, cycles, gap;
    bit advPrev, midDone;
    logic [VW-1:0] e;
    total = n + A - 1;
    idx = 0; beat = 0; drainLeft = 0; cycles = 0; gap = 0;
    advPrev = 0; midDone = 0;
    start = 1;
    num_vectors = CW'(n);
    in_valid = 0;
    @(posedge clk); #1;
    start = 0;
    if (n == 0) begin
      checkOutput("zeroDone", done, 1);
      checkOutput("zeroBusy", busy, 0);
      checkOutput("zeroValid", act_valid, 0);
      @(posedge clk); #1;
      checkOutput("zeroDonePulse", done, 0);
      checkOutput("zeroValid2", act_valid, 0);
      checkOutput("zeroBusy2", busy, 0);
      return;
    end
    forever begin
      checkOutput("valid", act_valid, advPrev);
      if (advPrev) begin
        e = expBeat(n, beat);
        checkOutput("data", act_out, e);
        checkOutput("last", act_last, beat == total - 1);
        lastOut = e;
        haveLast = 1;
        beat++;
      end else if (haveLast) begin
        checkOutput("hold", act_out, lastOut);
      end
      if (!advPrev && beat == total) begin
        checkOutput("done", done, 1);
        checkOutput("busyDrop", busy, 0);
        checkOutput("readyIdle", in_ready, 0);
        start = 0;
        in_valid = 0;
        return;
      end
      checkOutput("busy", busy, 1);
      checkOutput("noDone", done, 0);
      checkOutput("ready", in_ready, idx < n);
      if (abortAfter >= 0 && beat == abortAfter) begin
        abort = 1;
        in_valid = 0;
        @(posedge clk); #1;
        abort = 0;
        checkOutput("abortValid", act_valid, 0);
        checkOutput("abortLast", act_last, 0);
        checkOutput("abortDone", done, 0);
        checkOutput("abortBusy", busy, 0);
        checkOutput("abortReady", in_ready, 0);
        haveLast = 0;
        @(posedge clk); #1;
        checkOutput("abortDone2", done, 0);
        checkOutput("abortValid2", act_valid, 0);
        return;
      end
      start = 0;
      if (midStart && idx == 1 && !midDone) begin
        start = 1;
        num_vectors = CW'(n + 3);
        midDone = 1;
      end
      in_data = VW'($urandom);
      if (idx < n) begin
        if (stallPct < 0) begin
          in_valid = !(idx == 1 && gap < -stallPct);
          if (!in_valid) gap++;
        end else begin
          in_valid = ($urandom_range(0, 99) >= stallPct);
        end
        if (in_valid) begin
          in_data = vecs[idx];
          idx++;
          if (idx == n) drainLeft = A - 1;
        end
        advPrev = in_valid;
      end else begin
        in_valid = 0;
        advPrev = (drainLeft > 0);
        if (drainLeft > 0) drainLeft--;
      end
      @(posedge clk); #1;
      cycles++;
      if (cycles > 40 * total + 20) begin
        checkOutput("timeout", cycles, 0);
        start = 0;
        in_valid = 0;
        return;
      end
    end
  endtask

  task automatic resetMidFeed();
    start = 1;
    num_vectors = CW'(3);
    @(posedge clk); #1;
    start = 0;
    in_valid = 1;
    in_data = VW'($urandom) | VW'(1);
    @(posedge clk); #1;
    checkOutput("preResetValid", act_valid, 1);
    in_data = VW'($urandom);
    #2 rst_n = 0;
    #1;
    checkOutput("rstOut", act_out, 0);
    checkOutput("rstValid", act_valid, 0);
    checkOutput("rstLast", act_last, 0);
    checkOutput("rstDone", done, 0);
    checkOutput("rstBusy", busy, 0);
    checkOutput("rstReady", in_ready, 0);
    in_valid = 0;
    @(posedge clk); #1;
    rst_n = 1;
    lastOut = '0;
    haveLast = 1;
  endtask

  initial begin
    rst_n = 0; start = 0; abort = 0; in_valid = 0;
    in_data = '0; num_vectors = '0;
    lastOut = '0; haveLast = 1;
    #12;
    checkOutput("resetOut", act_out, 0);
    checkOutput("resetValid", act_valid, 0);
    checkOutput("resetLast", act_last, 0);
    checkOutput("resetDone", done, 0);
    checkOutput("resetBusy", busy, 0);
    checkOutput("resetReady", in_ready, 0);
    @(posedge clk); #1;
    rst_n = 1;
    idleCycles(2);

    $display("[TB] basic skew");
    vecs[0] = 32'h04030201;
    vecs[1] = 32'h08070605;
    applyStimulus(2, 0, -1, 0);
    idleCycles(2);

    $display("[TB] fixed 3-cycle stall");
    applyStimulus(2, -3, -1, 0);
    idleCycles(1);

    $display("[TB] zero-length tile");
    applyStimulus(0, 0, -1, 0);
    idleCycles(1);

    $display("[TB] abort in drain then fresh tile");
    applyStimulus(2, 0, 4, 0);
    idleCycles(1);
    vecs[0] = 32'h0A0B0C0D;
    applyStimulus(1, 0, -1, 0);
    idleCycles(1);

    $display("[TB] start while busy");
    fillRandom(5);
    applyStimulus(5, 20, -1, 1);
    idleCycles(1);

    $display("[TB] reset mid-feed");
    resetMidFeed();
    idleCycles(1);

    $display("[TB] back-to-back random tiles");
    for (int t = 0; t < 12; t++) begin
      int n;
      n = $urandom_range(0, 12);
      fillRandom(n);
      applyStimulus(n, $urandom_range(0, 40), -1, 0);
    end
    idleCycles(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
